piece_ctrl_fsm: RTL and testbench

- Sequences the single active falling piece: spawn, move, rotate, gravity, hard drop and lock.
- Owns the active_piece_grid_t and no_piece signals consumed by the piece-overlay blitter.
- Checks every candidate position against the locked board.
- Hands finished pieces to the board owner through a lock handshake.

---
 rtl/piece_ctrl_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_piece_ctrl_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_ctrl_fsm.sv
// Active falling-piece controller: spawn, move, rotate, gravity, hard drop and lock handshake.
// Optional build macro WALL_KICK_EN enables x-1 / x+1 retries for blocked rotations.
package piece_ctrl_pkg;
  typedef logic [3:0][3:0] piece_t;

  typedef struct packed {
    logic [9:0][19:0] screen;
  } game_state_t;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    piece_t     piece;
  } active_piece_grid_t;
endpackage

module piece_ctrl_fsm #(
  parameter logic [4:0] SPAWN_X = 5'd7,
  parameter logic [4:0] SPAWN_Y = 5'd4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  piece_ctrl_pkg::game_state_t         base_state,
  input  logic                                spawn_valid,
  input  logic [2:0]                          spawn_type,
  output logic                                spawn_ready,
  input  logic                                mv_left,
  input  logic                                mv_right,
  input  logic                                rot_cw,
  input  logic                                hard_drop,
  input  logic                                gravity_tick,
  output piece_ctrl_pkg::active_piece_grid_t  active_piece_grid,
  output logic                                no_piece,
  output logic                                lock_valid,
  input  logic                                lock_ready,
  output logic                                game_over
);
  import piece_ctrl_pkg::*;

  localparam logic [2:0] S_WAIT_SPAWN = 3'd0;
  localparam logic [2:0] S_SPAWN_CHK  = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_CHECK      = 3'd3;
  localparam logic [2:0] S_LOCK       = 3'd4;
  localparam logic [2:0] S_OVER       = 3'd5;

  localparam logic [1:0] OP_MOVE = 2'd0;
  localparam logic [1:0] OP_ROT  = 2'd1;
  localparam logic [1:0] OP_GRAV = 2'd2;
  localparam logic [1:0] OP_DROP = 2'd3;

  // Pending/request bit positions
  localparam int unsigned R_DROP  = 4;
  localparam int unsigned R_ROT   = 3;
  localparam int unsigned R_LEFT  = 2;
  localparam int unsigned R_RIGHT = 1;
  localparam int unsigned R_GRAV  = 0;

  function automatic piece_t base_shape(input logic [2:0] t);
    piece_t p;
    p = '0;
    case (t)
      3'd0: begin p[0][1] = 1'b1; p[1][1] = 1'b1; p[2][1] = 1'b1; p[3][1] = 1'b1; end
      3'd1: begin p[1][1] = 1'b1; p[2][1] = 1'b1; p[1][2] = 1'b1; p[2][2] = 1'b1; end
      3'd2: begin p[0][1] = 1'b1; p[1][1] = 1'b1; p[2][1] = 1'b1; p[1][0] = 1'b1; end
      3'd3: begin p[1][0] = 1'b1; p[2][0] = 1'b1; p[0][1] = 1'b1; p[1][1] = 1'b1; end
      3'd4: begin p[0][0] = 1'b1; p[1][0] = 1'b1; p[1][1] = 1'b1; p[2][1] = 1'b1; end
      3'd5: begin p[0][0] = 1'b1; p[0][1] = 1'b1; p[1][1] = 1'b1; p[2][1] = 1'b1; end
      3'd6: begin p[2][0] = 1'b1; p[0][1] = 1'b1; p[1][1] = 1'b1; p[2][1] = 1'b1; end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Clockwise quarter turn inside the 4x4 box (dy grows downward); O sits centred so it is invariant.
  function automatic piece_t turn_cw(input piece_t p);
    piece_t r;
    r = '0;
    for (int unsigned dx = 0; dx < 4; dx++) begin
      for (int unsigned dy = 0; dy < 4; dy++) begin
        r[dx[1:0]][dy[1:0]] = p[dy[1:0]][2'(3 - dx)];
      end
    end
    return r;
  endfunction

  function automatic piece_t shape_rom(input logic [2:0] t, input logic [1:0] rot);
    piece_t r0, r1, r2, r3, res;
    r0 = base_shape(t);
    r1 = turn_cw(r0);
    r2 = turn_cw(r1);
    r3 = turn_cw(r2);
    case (rot)
      2'd0:    res = r0;
      2'd1:    res = r1;
      2'd2:    res = r2;
      default: res = r3;
    endcase
    return res;
  endfunction

  logic [2:0] state_q, state_d;
  logic [4:0] x_q, x_d, y_q, y_d;
  piece_t     piece_q, piece_d;
  logic [2:0] type_q, type_d;
  logic [1:0] rot_q, rot_d;
  logic [4:0] cx_q, cx_d, cy_q, cy_d;
  logic [1:0] crot_q, crot_d;
  logic [1:0] op_q, op_d;
  logic [4:0] pend_q, pend_d;
  logic       no_piece_q, no_piece_d;
  logic       lock_valid_q, lock_valid_d;
  logic       game_over_q, game_over_d;
  logic       spawn_ready_q, spawn_ready_d;
`ifdef WALL_KICK_EN
  logic [1:0] kick_q, kick_d;
`endif

  piece_t     cand_piece;
  logic       collide;
  logic [4:0] req, eff;

  assign cand_piece = shape_rom(type_q, crot_q);
  assign req = {hard_drop, rot_cw, mv_left, mv_right, gravity_tick};
  assign eff = req | pend_q;

  always_comb begin
    int col;
    int row;
    col = 0;
    row = 0;
    collide = 1'b0;
    for (int unsigned dx = 0; dx < 4; dx++) begin
      for (int unsigned dy = 0; dy < 4; dy++) begin
        if (cand_piece[dx[1:0]][dy[1:0]]) begin
          col = int'(cx_q) + int'(dx) - 4;
          row = int'(cy_q) + int'(dy) - 4;
          if (col < 0 || col > 9 || row > 19) begin
            collide = 1'b1;
          end else if (row >= 0 && base_state.screen[col[3:0]][row[4:0]]) begin
            collide = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    piece_d      = piece_q;
    type_d       = type_q;
    rot_d        = rot_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    crot_d       = crot_q;
    op_d         = op_q;
    pend_d       = pend_q;
    no_piece_d   = no_piece_q;
    game_over_d  = game_over_q;
`ifdef WALL_KICK_EN
    kick_d       = kick_q;
`endif

    case (state_q)
      S_WAIT_SPAWN: begin
        pend_d = pend_q | req;
        if (spawn_ready_q && spawn_valid && spawn_type != 3'd7) begin
          type_d  = spawn_type;
          rot_d   = 2'd0;
          x_d     = SPAWN_X;
          y_d     = SPAWN_Y;
          piece_d = shape_rom(spawn_type, 2'd0);
          cx_d    = SPAWN_X;
          cy_d    = SPAWN_Y;
          crot_d  = 2'd0;
          state_d = S_SPAWN_CHK;
        end
      end

      S_SPAWN_CHK: begin
        pend_d = pend_q | req;
        if (collide) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end else begin
          no_piece_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_IDLE: begin
        // Unserviced live pulses fall into pending; left+right together cancel without using the visit.
        pend_d = eff;
        cx_d   = x_q;
        cy_d   = y_q;
        crot_d = rot_q;
`ifdef WALL_KICK_EN
        kick_d = 2'd0;
`endif
        if (eff[R_LEFT] && eff[R_RIGHT] && !eff[R_DROP] && !eff[R_ROT]) begin
          pend_d[R_LEFT]  = 1'b0;
          pend_d[R_RIGHT] = 1'b0;
        end
        if (eff[R_DROP]) begin
          op_d           = OP_DROP;
          cy_d           = y_q + 5'd1;
          pend_d[R_DROP] = 1'b0;
          state_d        = S_CHECK;
        end else if (eff[R_ROT]) begin
          op_d          = OP_ROT;
          crot_d        = rot_q + 2'd1;
          pend_d[R_ROT] = 1'b0;
          state_d       = S_CHECK;
        end else if (eff[R_LEFT] != eff[R_RIGHT]) begin
          op_d            = OP_MOVE;
          cx_d            = eff[R_LEFT] ? x_q - 5'd1 : x_q + 5'd1;
          pend_d[R_LEFT]  = 1'b0;
          pend_d[R_RIGHT] = 1'b0;
          state_d         = S_CHECK;
        end else if (eff[R_GRAV]) begin
          op_d           = OP_GRAV;
          cy_d           = y_q + 5'd1;
          pend_d[R_GRAV] = 1'b0;
          state_d        = S_CHECK;
        end
      end

      S_CHECK: begin
        pend_d = pend_q | req;
        if (!collide) begin
          x_d     = cx_q;
          y_d     = cy_q;
          rot_d   = crot_q;
          piece_d = cand_piece;
          if (op_q == OP_DROP) begin
            cy_d = cy_q + 5'd1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          case (op_q)
            OP_GRAV, OP_DROP: state_d = S_LOCK;
            OP_ROT: begin
`ifdef WALL_KICK_EN
              // Kick offsets are taken from the committed x, not the previous retry.
              if (kick_q == 2'd0) begin
                cx_d   = x_q - 5'd1;
                kick_d = 2'd1;
              end else if (kick_q == 2'd1) begin
                cx_d   = x_q + 5'd1;
                kick_d = 2'd2;
              end else begin
                state_d = S_IDLE;
              end
`else
              state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_LOCK: begin
        pend_d = pend_q | req;
        if (lock_valid_q && lock_ready) begin
          no_piece_d = 1'b1;
          pend_d     = '0;
          state_d    = S_WAIT_SPAWN;
        end
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: state_d = S_WAIT_SPAWN;
    endcase

    lock_valid_d  = (state_d == S_LOCK);
    spawn_ready_d = (state_d == S_WAIT_SPAWN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_WAIT_SPAWN;
      x_q           <= SPAWN_X;
      y_q           <= SPAWN_Y;
      piece_q       <= '0;
      type_q        <= '0;
      rot_q         <= '0;
      cx_q          <= SPAWN_X;
      cy_q          <= SPAWN_Y;
      crot_q        <= '0;
      op_q          <= OP_MOVE;
      pend_q        <= '0;
      no_piece_q    <= 1'b1;
      lock_valid_q  <= 1'b0;
      game_over_q   <= 1'b0;
      spawn_ready_q <= 1'b0;
`ifdef WALL_KICK_EN
      kick_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      piece_q       <= piece_d;
      type_q        <= type_d;
      rot_q         <= rot_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      crot_q        <= crot_d;
      op_q          <= op_d;
      pend_q        <= pend_d;
      no_piece_q    <= no_piece_d;
      lock_valid_q  <= lock_valid_d;
      game_over_q   <= game_over_d;
      spawn_ready_q <= spawn_ready_d;
`ifdef WALL_KICK_EN
      kick_q        <= kick_d;
`endif
    end
  end

  always_comb begin
    active_piece_grid.x     = x_q;
    active_piece_grid.y     = y_q;
    active_piece_grid.piece = piece_q;
  end

  assign no_piece    = no_piece_q;
  assign lock_valid  = lock_valid_q;
  assign game_over   = game_over_q;
  assign spawn_ready = spawn_ready_q;

endmodule

// File: tb/tb_piece_ctrl_fsm.sv
// Directed bench for piece_ctrl_fsm: spawn, wall stops, hard drop/lock, request priority, game over, rotation at a wall.
module tb_piece_ctrl_fsm;
  import piece_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  game_state_t        base_state;
  logic               spawn_valid;
  logic [2:0]         spawn_type;
  logic               spawn_ready;
  logic               mv_left, mv_right, rot_cw, hard_drop, gravity_tick;
  active_piece_grid_t grid;
  logic               no_piece, lock_valid, lock_ready, game_over;

  int total = 0;
  int bad   = 0;

  piece_ctrl_fsm #(.SPAWN_X(5'd7), .SPAWN_Y(5'd4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .base_state        (base_state),
    .spawn_valid       (spawn_valid),
    .spawn_type        (spawn_type),
    .spawn_ready       (spawn_ready),
    .mv_left           (mv_left),
    .mv_right          (mv_right),
    .rot_cw            (rot_cw),
    .hard_drop         (hard_drop),
    .gravity_tick      (gravity_tick),
    .active_piece_grid (grid),
    .no_piece          (no_piece),
    .lock_valid        (lock_valid),
    .lock_ready        (lock_ready),
    .game_over         (game_over)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    spawn_valid  = 1'b0;
    spawn_type   = 3'd0;
    mv_left      = 1'b0;
    mv_right     = 1'b0;
    rot_cw       = 1'b0;
    hard_drop    = 1'b0;
    gravity_tick = 1'b0;
    lock_ready   = 1'b0;
    base_state   = '0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic spawn_piece(input logic [2:0] t);
    spawn_valid = 1'b1;
    spawn_type  = t;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!no_piece) break;
    end
    spawn_valid = 1'b0;
    total++;
    if (no_piece !== 1'b0) begin
      bad++;
      $display("FAIL spawn_timeout type=%0d: no_piece got %0b want 0", t, no_piece);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    spawn_valid = 1'b0; spawn_type = 3'd0; mv_left = 1'b0; mv_right = 1'b0;
    rot_cw = 1'b0; hard_drop = 1'b0; gravity_tick = 1'b0; lock_ready = 1'b0;
    base_state = '0;
    step(2);
    total++;
    if ({no_piece, lock_valid, game_over, spawn_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 1000", {no_piece, lock_valid, game_over, spawn_ready});
    end
    total++;
    if (grid !== {5'd7, 5'd4, 16'h0000}) begin
      bad++;
      $display("FAIL reset_grid: got %h want %h", grid, {5'd7, 5'd4, 16'h0000});
    end
    reset_n = 1'b1;
    step(1);
    total++;
    if (spawn_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_spawn_ready: got %b want 1", spawn_ready);
    end
  endtask

  task automatic test_spawn();
    apply_reset();
    step(1);
    spawn_valid = 1'b1;
    spawn_type  = 3'd7;
    step(3);
    total++;
    if (no_piece !== 1'b1 || spawn_ready !== 1'b1) begin
      bad++;
      $display("FAIL spawn_illegal_type: no_piece=%b spawn_ready=%b want 1 1", no_piece, spawn_ready);
    end
    spawn_type = 3'd2;
    step(1);
    total++;
    if (spawn_ready !== 1'b0) begin
      bad++;
      $display("FAIL spawn_ready_drop: got %b want 0", spawn_ready);
    end
    spawn_valid = 1'b0;
    step(1);
    total++;
    if (grid !== {5'd7, 5'd4, 16'h0232} || no_piece !== 1'b0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL spawn_t: grid %h np=%b go=%b want %h 0 0", grid, no_piece, game_over,
               {5'd7, 5'd4, 16'h0232});
    end
  endtask

  task automatic test_left_wall();
    logic [4:0] exp_x [6];
    exp_x = '{5'd6, 5'd5, 5'd4, 5'd4, 5'd4, 5'd4};
    apply_reset();
    spawn_piece(3'd0);
    for (int i = 0; i < 6; i++) begin
      mv_left = 1'b1;
      step(1);
      mv_left = 1'b0;
      step(3);
      total++;
      if (grid.x !== exp_x[i] || grid.y !== 5'd4) begin
        bad++;
        $display("FAIL left_wall[%0d]: x=%0d y=%0d want x=%0d y=4", i, grid.x, grid.y, exp_x[i]);
      end
    end
    mv_right = 1'b1;
    step(1);
    mv_right = 1'b0;
    step(3);
    total++;
    if (grid.x !== 5'd5) begin
      bad++;
      $display("FAIL right_step: x=%0d want 5", grid.x);
    end
    mv_left = 1'b1;
    mv_right = 1'b1;
    step(1);
    mv_left = 1'b0;
    mv_right = 1'b0;
    step(3);
    total++;
    if (grid.x !== 5'd5 || grid.piece !== 16'h2222) begin
      bad++;
      $display("FAIL left_right_cancel: x=%0d piece=%h want 5 2222", grid.x, grid.piece);
    end
  endtask

  task automatic test_hard_drop_lock();
    apply_reset();
    spawn_piece(3'd1);
    total++;
    if (grid.piece !== 16'h0660) begin
      bad++;
      $display("FAIL o_shape: got %h want 0660", grid.piece);
    end
    hard_drop = 1'b1;
    step(1);
    hard_drop = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      total++;
      if (grid.y !== 5'(4 + i) || lock_valid !== 1'b0) begin
        bad++;
        $display("FAIL drop_row[%0d]: y=%0d lv=%b want y=%0d lv=0", i, grid.y, lock_valid, 4 + i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (lock_valid !== 1'b1 || grid.y !== 5'd21 || grid.x !== 5'd7) begin
        bad++;
        $display("FAIL lock_hold[%0d]: lv=%b x=%0d y=%0d want 1 7 21", i, lock_valid, grid.x, grid.y);
      end
    end
    lock_ready = 1'b1;
    step(1);
    lock_ready = 1'b0;
    total++;
    if ({no_piece, lock_valid, spawn_ready} !== 3'b101 || grid.y !== 5'd21) begin
      bad++;
      $display("FAIL lock_exit: np/lv/sr=%b y=%0d want 101 21", {no_piece, lock_valid, spawn_ready}, grid.y);
    end
  endtask

  task automatic test_move_and_gravity();
    apply_reset();
    spawn_piece(3'd2);
    mv_left = 1'b1;
    gravity_tick = 1'b1;
    step(1);
    mv_left = 1'b0;
    gravity_tick = 1'b0;
    step(1);
    total++;
    if (grid.x !== 5'd6 || grid.y !== 5'd4) begin
      bad++;
      $display("FAIL left_first: x=%0d y=%0d want 6 4", grid.x, grid.y);
    end
    step(1);
    total++;
    if (grid.y !== 5'd4) begin
      bad++;
      $display("FAIL grav_not_early: y=%0d want 4", grid.y);
    end
    step(1);
    total++;
    if (grid.y !== 5'd5 || grid.x !== 5'd6) begin
      bad++;
      $display("FAIL grav_pending: x=%0d y=%0d want 6 5", grid.x, grid.y);
    end
  endtask

  task automatic test_game_over();
    apply_reset();
    for (int c = 3; c <= 6; c++) begin
      for (int r = 0; r <= 3; r++) begin
        base_state.screen[c][r] = 1'b1;
      end
    end
    spawn_valid = 1'b1;
    spawn_type  = 3'd3;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (game_over) break;
    end
    spawn_valid = 1'b0;
    total++;
    if ({game_over, no_piece, spawn_ready} !== 3'b110) begin
      bad++;
      $display("FAIL game_over_set: go/np/sr=%b want 110", {game_over, no_piece, spawn_ready});
    end
    base_state  = '0;
    spawn_valid = 1'b1;
    mv_left = 1'b1;
    hard_drop = 1'b1;
    step(6);
    mv_left = 1'b0;
    hard_drop = 1'b0;
    spawn_valid = 1'b0;
    total++;
    if ({game_over, no_piece, spawn_ready, lock_valid} !== 4'b1100 || grid.x !== 5'd7 || grid.y !== 5'd4) begin
      bad++;
      $display("FAIL game_over_sticky: flags=%b x=%0d y=%0d want 1100 7 4",
               {game_over, no_piece, spawn_ready, lock_valid}, grid.x, grid.y);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (game_over !== 1'b0 || no_piece !== 1'b1) begin
      bad++;
      $display("FAIL game_over_reset: go=%b np=%b want 0 1", game_over, no_piece);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_rotate_wall();
    apply_reset();
    spawn_piece(3'd0);
    rot_cw = 1'b1;
    step(1);
    rot_cw = 1'b0;
    step(3);
    total++;
    if (grid.piece !== 16'h0F00 || grid.x !== 5'd7) begin
      bad++;
      $display("FAIL rot_vertical: piece=%h x=%0d want 0f00 7", grid.piece, grid.x);
    end
    for (int i = 0; i < 5; i++) begin
      mv_right = 1'b1;
      step(1);
      mv_right = 1'b0;
      step(3);
    end
    total++;
    if (grid.x !== 5'd11) begin
      bad++;
      $display("FAIL right_wall: x=%0d want 11", grid.x);
    end
    rot_cw = 1'b1;
    step(1);
    rot_cw = 1'b0;
    step(6);
`ifdef WALL_KICK_EN
    total++;
    if (grid.piece !== 16'h4444 || grid.x !== 5'd10) begin
      bad++;
      $display("FAIL rot_kick: piece=%h x=%0d want 4444 10", grid.piece, grid.x);
    end
`else
    total++;
    if (grid.piece !== 16'h0F00 || grid.x !== 5'd11) begin
      bad++;
      $display("FAIL rot_blocked: piece=%h x=%0d want 0f00 11", grid.piece, grid.x);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spawn();
    test_left_wall();
    test_hard_drop_lock();
    test_move_and_gravity();
    test_game_over();
    test_rotate_wall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
